// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: hazard/redirect controls from decode, the instruction-memory
// address/stop/data path, and the instruction stream handed to decode.
interface fetch_unit_if;
    logic        i_stall;
    logic        i_redirect;
    logic [11:0] i_target;
    logic [11:0] o_pc;
    logic        o_mem_stop;
    logic [15:0] i_mem_instr;
    logic [15:0] o_instr;
    logic [11:0] o_instr_pc;
    logic        o_valid;
    logic        o_halted;

    // The fetch unit initiates memory reads, so it is the master side.
    modport master (
        input  i_stall, i_redirect, i_target, i_mem_instr,
        output o_pc, o_mem_stop, o_instr, o_instr_pc, o_valid, o_halted
    );

    modport slave (
        output i_stall, i_redirect, i_target, i_mem_instr,
        input  o_pc, o_mem_stop, o_instr, o_instr_pc, o_valid, o_halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives the PC, realigns registered memory data with
// its PC, and handles stall/redirect. Define FETCH_HALT_EN to enable the HALT opcode.
module fetch_unit #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fetch_unit_if.master  bus
);

`ifdef FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [11:0] pc_reg;
    logic [11:0] fpc_reg;
    logic        valid_reg;
    logic [0:0]  state;
    logic        halt_hit;

    assign bus.o_pc       = pc_reg;
    assign bus.o_instr    = bus.i_mem_instr;
    assign bus.o_instr_pc = fpc_reg;
    assign bus.o_valid    = valid_reg && (state == ST_RUN);
    assign bus.o_halted   = HALT_EN && (state == ST_HALT);

    assign halt_hit = HALT_EN && bus.o_valid && (bus.i_mem_instr[15:12] == HALT_OPCODE);

    // A redirect must let the memory advance even while stalled or halted, so the
    // target's data follows one edge behind the new PC.
    assign bus.o_mem_stop = !bus.i_redirect
                            && (bus.i_stall || (state == ST_HALT) || halt_hit);

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; the reset branch is asynchronous and needs no clock.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_reg    <= RESET_PC;
            fpc_reg   <= RESET_PC;
            valid_reg <= 1'b0;
            state     <= ST_RUN;
        end else if (bus.i_redirect) begin
            pc_reg    <= bus.i_target;
            valid_reg <= 1'b0;
            state     <= ST_RUN;
        end else if (state == ST_HALT || bus.i_stall) begin
            pc_reg    <= pc_reg;
        end else if (halt_hit) begin
            state     <= ST_HALT;
            valid_reg <= 1'b0;
        end else begin
            fpc_reg   <= pc_reg;
            pc_reg    <= pc_reg + 12'd1;
            valid_reg <= 1'b1;
        end
    end

endmodule
